// File: rtl/timer_irq.sv
// timer_irq: bus-mapped down-counting timer (CTRL / PRESET / COUNT) that raises a
// maskable interrupt flag when the count expires, in one-shot or auto-reload mode.
module timer_irq #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        addr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              irq
);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [3:0]        ctrl;
    logic [DATA_W-1:0] preset;
    logic [DATA_W-1:0] count;
    logic              irq_flag;

    logic              en;
    logic              auto_reload;
    logic              ctrl_wr;
    logic              preset_wr;

    logic              load_count;
    logic              dec_count;
    logic              set_flag;
    logic              clr_flag;
    logic              clr_en;

    // Counting saturates at zero: a count of 1 or 0 both expire to 0.
    function automatic logic [DATA_W-1:0] sat_dec(input logic [DATA_W-1:0] x);
        return (x > DATA_W'(1)) ? (x - DATA_W'(1)) : '0;
    endfunction

    assign en          = ctrl[0];
    assign auto_reload = (ctrl[2:1] == 2'b01);
    assign ctrl_wr     = we && (addr == ADDR_CTRL);
    assign preset_wr   = we && (addr == ADDR_PRESET);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = CNT;
            end
            CNT: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (count <= DATA_W'(1)) begin
                    state_nxt = INT;
                end
            end
            INT: begin
                state_nxt = auto_reload ? LOAD : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        load_count = 1'b0;
        dec_count  = 1'b0;
        set_flag   = 1'b0;
        clr_flag   = 1'b0;
        clr_en     = 1'b0;
        case (state)
            LOAD: begin
                load_count = 1'b1;
            end
            CNT: begin
                if (en) begin
                    dec_count = 1'b1;
                    set_flag  = (count <= DATA_W'(1));
                end
            end
            INT: begin
                if (auto_reload) begin
                    clr_flag = 1'b1;
                end else begin
                    clr_en = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // A CPU write to CTRL takes precedence over the FSM clearing EN.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl <= '0;
        end else if (ctrl_wr) begin
            ctrl <= wdata[3:0];
        end else if (clr_en) begin
            ctrl[0] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            preset <= '0;
        end else if (preset_wr) begin
            preset <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load_count) begin
            count <= preset;
        end else if (dec_count) begin
            count <= sat_dec(count);
        end
    end

    // Any register write acknowledges the interrupt, even on the edge it would fire.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_flag <= 1'b0;
        end else if (ctrl_wr || preset_wr) begin
            irq_flag <= 1'b0;
        end else if (set_flag) begin
            irq_flag <= 1'b1;
        end else if (clr_flag) begin
            irq_flag <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        if (!reset) begin
            case (addr)
                ADDR_CTRL:   rdata = {{(DATA_W-4){1'b0}}, ctrl};
                ADDR_PRESET: rdata = preset;
                ADDR_COUNT:  rdata = count;
                default:     rdata = '0;
            endcase
        end
    end

    assign irq = irq_flag & ctrl[3];

endmodule

// File: tb/tb_timer_irq.sv
// Bench for timer_irq: directed vector table, multi-cycle corner sequences and
// randomized bus traffic compared against a behavioural model of the timer.
module tb_timer_irq;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    timer_irq dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    // Behavioural model: phase 0 idle, 1 about to load, 2 counting down, 3 just expired.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_flag;
    int          m_phase;

    typedef struct {
        logic        rst;
        logic        wr;
        logic [1:0]  a;
        logic [31:0] d;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic w, input logic [1:0] a,
                                input logic [31:0] d, input logic [31:0] er, input logic ei);
        vec_t v;
        v.rst = r; v.wr = w; v.a = a; v.d = d; v.exp_rdata = er; v.exp_irq = ei;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        if (reset) return 32'h0;
        case (a)
            2'd0:    return {28'h0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        logic [3:0]  n_ctrl;
        logic [31:0] n_preset;
        logic [31:0] n_count;
        logic        n_flag;
        int          n_phase;
        if (reset) begin
            m_ctrl = 4'h0; m_preset = 32'h0; m_count = 32'h0; m_flag = 1'b0; m_phase = 0;
        end else begin
            n_ctrl = m_ctrl; n_preset = m_preset; n_count = m_count;
            n_flag = m_flag; n_phase = m_phase;
            case (m_phase)
                0: if (m_ctrl[0]) n_phase = 1;
                1: begin n_count = m_preset; n_phase = 2; end
                2: begin
                    if (!m_ctrl[0]) n_phase = 0;
                    else if (m_count > 1) n_count = m_count - 1;
                    else begin n_count = 0; n_flag = 1'b1; n_phase = 3; end
                end
                default: begin
                    if (m_ctrl[2:1] == 2'b01) begin n_flag = 1'b0; n_phase = 1; end
                    else begin n_ctrl[0] = 1'b0; n_phase = 0; end
                end
            endcase
            if (we && addr == 2'd0) begin n_ctrl = wdata[3:0]; n_flag = 1'b0; end
            if (we && addr == 2'd1) begin n_preset = wdata; n_flag = 1'b0; end
            m_ctrl = n_ctrl; m_preset = n_preset; m_count = n_count;
            m_flag = n_flag; m_phase = n_phase;
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d);
        reset = r; we = w; addr = a; wdata = d;
        #1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 2'd0, 32'h0);
        edge_step();
        drive(1'b0, 1'b0, 2'd0, 32'h0);
    endtask

    initial begin
        logic        r;
        logic        w;
        logic [1:0]  a;
        logic [31:0] d;
        int          e;

        reset = 1'b1; we = 1'b0; addr = 2'd0; wdata = 32'h0;
        m_ctrl = 4'h0; m_preset = 32'h0; m_count = 32'h0; m_flag = 1'b0; m_phase = 0;
        drive(1'b1, 1'b0, 2'd0, 32'h0);
        edge_step();

        // Directed vectors: inputs applied before the edge, outputs checked before the edge.
        tbl.push_back(mk(1, 0, 2'd0, 32'h0,        32'h0, 0));
        tbl.push_back(mk(1, 1, 2'd1, 32'h5,        32'h0, 0));
        tbl.push_back(mk(0, 0, 2'd1, 32'h0,        32'h0, 0));
        tbl.push_back(mk(0, 1, 2'd1, 32'h3,        32'h0, 0));
        tbl.push_back(mk(0, 1, 2'd0, 32'h9,        32'h0, 0));
        tbl.push_back(mk(0, 0, 2'd2, 32'h0,        32'h0, 0));
        tbl.push_back(mk(0, 0, 2'd2, 32'h0,        32'h0, 0));
        tbl.push_back(mk(0, 0, 2'd2, 32'h0,        32'h3, 0));
        tbl.push_back(mk(0, 0, 2'd2, 32'h0,        32'h2, 0));
        tbl.push_back(mk(0, 0, 2'd2, 32'h0,        32'h1, 0));
        tbl.push_back(mk(0, 0, 2'd2, 32'h0,        32'h0, 1));
        tbl.push_back(mk(0, 0, 2'd0, 32'h0,        32'h8, 1));
        tbl.push_back(mk(0, 0, 2'd0, 32'h0,        32'h8, 1));
        tbl.push_back(mk(0, 1, 2'd0, 32'h8,        32'h8, 1));
        tbl.push_back(mk(0, 0, 2'd2, 32'h0,        32'h0, 0));
        tbl.push_back(mk(0, 1, 2'd3, 32'hFFFFFFFF, 32'h0, 0));
        tbl.push_back(mk(0, 1, 2'd2, 32'h12345678, 32'h0, 0));
        tbl.push_back(mk(0, 0, 2'd2, 32'h0,        32'h0, 0));
        tbl.push_back(mk(0, 0, 2'd0, 32'h0,        32'h8, 0));
        tbl.push_back(mk(0, 0, 2'd3, 32'h0,        32'h0, 0));
        tbl.push_back(mk(0, 1, 2'd0, 32'hF6,       32'h8, 0));
        tbl.push_back(mk(0, 0, 2'd0, 32'h0,        32'h6, 0));
        tbl.push_back(mk(0, 1, 2'd0, 32'h0,        32'h6, 0));
        tbl.push_back(mk(0, 0, 2'd0, 32'h0,        32'h0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].wr, tbl[i].a, tbl[i].d);
            chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rdata);
            chk1($sformatf("tbl%0d_irq", i), irq, tbl[i].exp_irq);
            edge_step();
        end

        // Auto-reload, PRESET=2: one-cycle pulse every 4 cycles, EN stays set.
        do_reset();
        drive(0, 1, 2'd1, 32'h2); edge_step();
        drive(0, 1, 2'd0, 32'hB); edge_step();
        for (int k = 1; k <= 16; k++) begin
            drive(0, 0, 2'd0, 32'h0);
            edge_step();
            chk1($sformatf("ar_irq_k%0d", k), irq, (k % 4 == 0));
            chk1($sformatf("ar_en_k%0d", k), rdata[0], 1'b1);
        end

        // Masked auto-reload with PRESET=1, then IM enabled mid-run.
        do_reset();
        drive(0, 1, 2'd1, 32'h1); edge_step();
        drive(0, 1, 2'd0, 32'h3); edge_step();
        for (int k = 1; k <= 15; k++) begin
            drive(0, (k == 10), 2'd0, 32'hB);
            edge_step();
            drive(0, 0, 2'd0, 32'h0);
            chk1($sformatf("mask_irq_k%0d", k), irq, (k == 12 || k == 15));
        end

        // Disable while counting, then re-enable restarts from PRESET.
        do_reset();
        drive(0, 1, 2'd1, 32'd10); edge_step();
        drive(0, 1, 2'd0, 32'h9);  edge_step();
        for (int k = 1; k <= 16; k++) begin
            drive(0, (k == 7 || k == 13), 2'd0, (k == 7) ? 32'h8 : 32'h9);
            edge_step();
            drive(0, 0, 2'd2, 32'h0);
            if (k < 2)        e = 0;
            else if (k <= 7)  e = 12 - k;
            else if (k <= 14) e = 5;
            else if (k == 15) e = 10;
            else              e = 9;
            chk($sformatf("dis_count_k%0d", k), rdata, 32'(e));
            chk1($sformatf("dis_irq_k%0d", k), irq, 1'b0);
        end

        // Reset in the middle of a count.
        do_reset();
        drive(0, 1, 2'd1, 32'd10); edge_step();
        drive(0, 1, 2'd0, 32'h9);  edge_step();
        for (int k = 1; k <= 8; k++) begin
            drive(0, 0, 2'd2, 32'h0);
            edge_step();
        end
        chk("rst_pre_count", rdata, 32'h4);
        drive(1, 0, 2'd2, 32'h0);
        edge_step();
        drive(0, 0, 2'd0, 32'h0);
        chk("rst_ctrl", rdata, 32'h0);
        chk1("rst_irq", irq, 1'b0);
        drive(0, 0, 2'd1, 32'h0);
        chk("rst_preset", rdata, 32'h0);
        drive(0, 0, 2'd2, 32'h0);
        chk("rst_count", rdata, 32'h0);
        for (int k = 1; k <= 15; k++) begin
            drive(0, 0, 2'd2, 32'h0);
            edge_step();
            chk1($sformatf("rst_post_irq_k%0d", k), irq, 1'b0);
        end

        // CPU CTRL write on the same edge the one-shot FSM clears EN; mode 11 acts as one-shot.
        do_reset();
        drive(0, 1, 2'd1, 32'h1); edge_step();
        drive(0, 1, 2'd0, 32'h9); edge_step();
        for (int k = 1; k <= 8; k++) begin
            drive(0, (k == 4), 2'd0, 32'hF);
            edge_step();
            drive(0, 0, 2'd0, 32'h0);
            if (k == 3) chk1("sim_irq_first", irq, 1'b1);
            if (k == 4) begin
                chk("sim_ctrl_won", rdata, 32'hF);
                chk1("sim_irq_cleared", irq, 1'b0);
            end
            if (k == 7) chk1("sim_irq_second", irq, 1'b1);
            if (k == 8) begin
                chk("sim_ctrl_oneshot", rdata, 32'hE);
                chk1("sim_irq_held", irq, 1'b1);
            end
        end

        // PRESET write during CNT leaves COUNT alone; PRESET=0 then fires like PRESET=1.
        do_reset();
        drive(0, 1, 2'd1, 32'h5); edge_step();
        drive(0, 1, 2'd0, 32'h9); edge_step();
        for (int k = 1; k <= 12; k++) begin
            drive(0, (k == 3 || k == 9), (k == 3) ? 2'd1 : 2'd0, (k == 3) ? 32'h0 : 32'h9);
            edge_step();
            drive(0, 0, 2'd2, 32'h0);
            if (k == 3)  chk("pre_count_k3", rdata, 32'h4);
            if (k == 6)  chk1("pre_irq_k6", irq, 1'b0);
            if (k == 7) begin
                chk("pre_count_k7", rdata, 32'h0);
                chk1("pre_irq_k7", irq, 1'b1);
            end
            if (k == 11) begin
                chk("pre_count_k11", rdata, 32'h0);
                chk1("pre_irq_k11", irq, 1'b0);
            end
            if (k == 12) chk1("pre_irq_k12", irq, 1'b1);
        end

        // Randomized bus traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 63) == 0);
            w = ($urandom_range(0, 5) == 0);
            a = 2'($urandom_range(0, 3));
            d = $urandom;
            if (a == 2'd1) d = 32'($urandom_range(0, 6));
            else if (a == 2'd0 && $urandom_range(0, 2) != 0) d[0] = 1'b1;
            drive(r, w, a, d);
            chk($sformatf("rand%0d_rdata", i), rdata, model_rd(a));
            chk1($sformatf("rand%0d_irq", i), irq, m_flag & m_ctrl[3]);
            edge_step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
